step_planner: RTL and testbench

STEP_PLANNER -- requirements
Module: step_planner

---
 rtl/step_planner_if.sv | 26 ++
 rtl/step_planner.sv | 110 +++++++++++
 tb/tb_step_planner.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/step_planner_if.sv
// Command/status bundle between a motion sequencer (master) and step_planner (slave).
// Carries the move request inputs and the registered driver/status outputs.
interface step_planner_if #(
  parameter int POS_W = 12
);
  logic             start;
  logic             stop;
  logic             home;
  logic [POS_W-1:0] target;
  logic             enabler;
  logic             cwccw;
  logic             onoff;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] position;

  modport master (
    output start, stop, home, target,
    input  enabler, cwccw, onoff, busy, done, position
  );

  modport slave (
    input  start, stop, home, target,
    output enabler, cwccw, onoff, busy, done, position
  );
endinterface

// File: rtl/step_planner.sv
// Point-to-point stepper move planner: walks position toward a captured target,
// issuing one enabler pulse every PERIOD cycles, with stop/home/abort handling.
module step_planner #(
  parameter int PERIOD = 50_000_000,
  parameter int POS_W  = 12
) (
  input  logic         clk,
  input  logic         reseteo,
  step_planner_if.slave bus
);

  localparam int              DIV_W  = $clog2(PERIOD);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(PERIOD - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [POS_W-1:0] r_position;
  logic [POS_W-1:0] r_tgt;
  logic             r_enabler;
  logic             r_cwccw;
  logic             r_onoff;
  logic             r_busy;
  logic             r_done;

  logic [POS_W-1:0] w_basePos;
  logic [POS_W-1:0] w_stepPos;
  logic             w_accept;
  logic             w_tick;

  // Home takes effect before a simultaneous start, so the move is planned from 0.
  assign w_basePos = bus.home ? '0 : r_position;
  assign w_accept  = bus.start && !bus.stop;
  assign w_tick    = (r_div == '0);
  assign w_stepPos = r_cwccw ? (r_position + POS_W'(1)) : (r_position - POS_W'(1));

  always_ff @(posedge clk or negedge reseteo) begin
    if (!reseteo) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_position <= '0;
      r_tgt      <= '0;
      r_enabler  <= 1'b0;
      r_cwccw    <= 1'b0;
      r_onoff    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_enabler <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.home) r_position <= '0;
          if (w_accept) begin
            r_tgt   <= bus.target;
            r_div   <= RELOAD;
            r_cwccw <= (bus.target > w_basePos);
            r_busy  <= 1'b1;
            if (bus.target != w_basePos) begin
              r_state <= S_RUN;
              r_onoff <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Stop wins over a coinciding divider expiry: no pulse, position frozen.
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_onoff <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            r_div      <= RELOAD;
            r_enabler  <= 1'b1;
            r_position <= w_stepPos;
            if (w_stepPos == r_tgt) begin
              r_state <= S_DONE;
              r_onoff <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_onoff <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enabler  = r_enabler;
  assign bus.cwccw    = r_cwccw;
  assign bus.onoff    = r_onoff;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.position = r_position;

endmodule

// File: tb/tb_step_planner.sv
// Self-checking bench for step_planner: schedule-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_step_planner;

  localparam int PERIOD = 4;
  localparam int POS_W  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  step_planner_if #(.POS_W(POS_W)) bus();

  step_planner #(.PERIOD(PERIOD), .POS_W(POS_W)) dut (
    .clk    (clk),
    .reseteo(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: a move is a schedule of steps at accept+k*PERIOD.
  logic [POS_W-1:0] mPos   = '0;
  logic [POS_W-1:0] mFrom  = '0;
  logic             mDir   = 1'b0;
  logic             mBusy  = 1'b0;
  logic             mOn    = 1'b0;
  logic             mDone  = 1'b0;
  logic             mEn    = 1'b0;
  logic             mMoving = 1'b0;
  logic             mInDone = 1'b0;
  int               mLen    = 0;
  int               mAccept = 0;
  int               edgeCnt = 0;

  int pulses     = 0;
  int dones      = 0;
  int busyCycles = 0;
  int onCycles   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPos = '0; mDir = 1'b0; mBusy = 1'b0; mOn = 1'b0; mDone = 1'b0; mEn = 1'b0;
      mMoving = 1'b0; mInDone = 1'b0; edgeCnt = 0;
    end else begin
      int elapsed;
      int taken;
      edgeCnt++;
      mEn   = 1'b0;
      mDone = 1'b0;
      if (mInDone) begin
        mInDone = 1'b0;
        mBusy   = 1'b0;
      end else if (mMoving) begin
        elapsed = edgeCnt - mAccept;
        if (bus.stop) begin
          mMoving = 1'b0; mBusy = 1'b0; mOn = 1'b0;
        end else if (elapsed % PERIOD == 0) begin
          taken = elapsed / PERIOD;
          mPos  = mDir ? POS_W'(int'(mFrom) + taken) : POS_W'(int'(mFrom) - taken);
          mEn   = 1'b1;
          if (taken == mLen) begin
            mMoving = 1'b0; mInDone = 1'b1; mDone = 1'b1; mOn = 1'b0;
          end
        end
      end else begin
        if (bus.home) mPos = '0;
        if (bus.start && !bus.stop) begin
          mFrom   = mPos;
          mDir    = (bus.target > mPos);
          mLen    = mDir ? int'(bus.target) - int'(mPos) : int'(mPos) - int'(bus.target);
          mAccept = edgeCnt;
          mBusy   = 1'b1;
          if (mLen == 0) begin
            mInDone = 1'b1; mDone = 1'b1;
          end else begin
            mMoving = 1'b1; mOn = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("enabler",  {31'd0, bus.enabler}, {31'd0, mEn});
      checkOutput("cwccw",    {31'd0, bus.cwccw},   {31'd0, mDir});
      checkOutput("onoff",    {31'd0, bus.onoff},   {31'd0, mOn});
      checkOutput("busy",     {31'd0, bus.busy},    {31'd0, mBusy});
      checkOutput("done",     {31'd0, bus.done},    {31'd0, mDone});
      checkOutput("position", 32'(bus.position),    32'(mPos));
      if (bus.enabler) pulses++;
      if (bus.done)    dones++;
      if (bus.busy)    busyCycles++;
      if (bus.onoff)   onCycles++;
    end
  end

  task automatic clearCounters();
    pulses = 0; dones = 0; busyCycles = 0; onCycles = 0;
  endtask

  // Drives one cycle of requests so they are sampled on the next rising edge.
  task automatic applyStimulus(input logic st, input logic sp, input logic hm, input logic [POS_W-1:0] tg);
    bus.start = st; bus.stop = sp; bus.home = hm; bus.target = tg;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.stop = 1'b0; bus.home = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (mBusy && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (mBusy) checkOutput({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_enabler"},  {31'd0, bus.enabler}, 32'd0);
    checkOutput({name, "_cwccw"},    {31'd0, bus.cwccw},   32'd0);
    checkOutput({name, "_onoff"},    {31'd0, bus.onoff},   32'd0);
    checkOutput({name, "_busy"},     {31'd0, bus.busy},    32'd0);
    checkOutput({name, "_done"},     {31'd0, bus.done},    32'd0);
    checkOutput({name, "_position"}, 32'(bus.position),    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0; bus.stop = 1'b0; bus.home = 1'b0; bus.target = '0;
    repeat (2) @(posedge clk);
    #2;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Forward move 0 -> 3
    clearCounters();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd3);
    n = 0;
    while (!bus.enabler && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("fwd_first_pulse_latency", 32'(n), 32'd4);
    waitIdle("fwd");
    checkOutput("fwd_pulses",   32'(pulses),        32'd3);
    checkOutput("fwd_position", 32'(bus.position),  32'd3);
    checkOutput("fwd_cwccw",    {31'd0, bus.cwccw}, 32'd1);
    checkOutput("fwd_dones",    32'(dones),         32'd1);
    checkOutput("fwd_onoff_cycles", 32'(onCycles),  32'd12);

    // Reverse move 3 -> 1
    clearCounters();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd1);
    waitIdle("rev");
    checkOutput("rev_pulses",   32'(pulses),        32'd2);
    checkOutput("rev_position", 32'(bus.position),  32'd1);
    checkOutput("rev_cwccw",    {31'd0, bus.cwccw}, 32'd0);
    checkOutput("rev_dones",    32'(dones),         32'd1);

    // Zero-length move at position 1
    clearCounters();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd1);
    checkOutput("zero_done_next_cycle", {31'd0, bus.done}, 32'd1);
    waitIdle("zero");
    checkOutput("zero_pulses",      32'(pulses),     32'd0);
    checkOutput("zero_busy_cycles", 32'(busyCycles), 32'd1);

    // Abort 1 -> 10 with stop on the second divider expiry
    clearCounters();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd10);
    repeat (2 * PERIOD - 1) begin
      @(posedge clk); #2;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 12'd0);
    checkOutput("abort_busy",     {31'd0, bus.busy},  32'd0);
    checkOutput("abort_position", 32'(bus.position),  32'd2);
    checkOutput("abort_pulses",   32'(pulses),        32'd1);
    checkOutput("abort_dones",    32'(dones),         32'd0);

    // Stop beats start in IDLE
    applyStimulus(1'b1, 1'b1, 1'b0, 12'd7);
    checkOutput("prio_busy",     {31'd0, bus.busy}, 32'd0);
    checkOutput("prio_position", 32'(bus.position), 32'd2);

    // Home together with start: move computed from 0
    clearCounters();
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd2);
    checkOutput("home_position_cleared", 32'(bus.position), 32'd0);
    waitIdle("home");
    checkOutput("home_pulses",   32'(pulses),        32'd2);
    checkOutput("home_position", 32'(bus.position),  32'd2);
    checkOutput("home_cwccw",    {31'd0, bus.cwccw}, 32'd1);

    // Asynchronous reset in the middle of a move
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd9);
    repeat (6) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
    end
    checkOutput("post_reset_idle", {31'd0, bus.busy}, 32'd0);

    // Random traffic checked cycle by cycle against the model
    for (int i = 0; i < 2000; i++) begin
      bus.start  = ($urandom_range(0, 5) == 0);
      bus.stop   = ($urandom_range(0, 39) == 0);
      bus.home   = ($urandom_range(0, 9) == 0);
      bus.target = POS_W'($urandom_range(0, 15));
      @(posedge clk); #2;
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.home = 1'b0;
    waitIdle("random");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
